// File: rtl/hazard_pkg.sv
// Shared types and helpers for the frontend hazard / dispatch-throttle logic.
package hazard_pkg;

    // Redirect recovery sequence: RUN is normal operation, FLUSH is the
    // cycle after a redirect, REFILL holds fetch off while the pipe refills.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        REFILL = 2'd2
    } flush_state_t;

    // Widest dispatch group any instance may use.
    localparam int MAX_LANES = 4;

    // Number of set bits in a lane vector (narrower vectors are zero-extended).
    function automatic logic [2:0] popcount(input logic [MAX_LANES-1:0] v);
        logic [2:0] c;
        c = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            c = c + {2'b00, v[i]};
        end
        return c;
    endfunction

    // Width needed to hold an occupancy count of 0..depth inclusive.
    function automatic int rob_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hazard_unit_lane_grant.sv
// Lowest-k lane selector: grants valid lanes from bit 0 upward until the
// number of free ROB slots is used up.
module lane_grant #(
    parameter int W  = 2,
    parameter int CW = 6
) (
    input  logic [W-1:0]  valid_i,
    input  logic [CW-1:0] free_i,
    output logic [W-1:0]  grant_o
);

    // Walk lanes in order, granting while slots remain.
    always_comb begin
        logic [CW-1:0] taken;
        taken   = '0;
        grant_o = '0;
        for (int i = 0; i < W; i++) begin
            if (valid_i[i] && (taken < free_i)) begin
                grant_o[i] = 1'b1;
                taken      = taken + CW'(1);
            end
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Frontend hazard unit: ROB occupancy tracking, dispatch grant, registered
// fetch stall and redirect recovery sequencing.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter  int ROB_DEPTH    = 32,
    parameter  int DISPATCH_W   = 2,
    parameter  int RETIRE_W     = 2,
    parameter  int FLUSH_CYCLES = 2,
    localparam int CW           = rob_cnt_w(ROB_DEPTH),
    localparam int RW           = $clog2(RETIRE_W + 1),
    localparam int FCW          = $clog2(FLUSH_CYCLES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  busy,
    input  logic                  overwrite_pc,
    input  logic [DISPATCH_W-1:0] instruction,
    input  logic [RW-1:0]         retire_count,
    input  logic                  rs_full,
    output logic [DISPATCH_W-1:0] dispatch_grant,
    output logic [CW-1:0]         rob_count,
    output logic                  rob_full,
    output logic                  rob_empty,
    output logic                  frontend_stall,
    output logic                  flushing
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           full_cycles,
    output logic [31:0]           flush_count
`endif
);

    flush_state_t          state_q, state_d;
    logic [FCW-1:0]        cnt_q, cnt_d;
    logic [CW-1:0]         rob_q, rob_d;
    logic                  stall_q, stall_d;
    logic [CW-1:0]         free_now, free_next;
    logic [DISPATCH_W-1:0] lane_gnt;
    logic [CW:0]           tot;
    logic                  underflow;

    assign flushing       = (state_q != RUN);
    assign rob_count      = rob_q;
    assign rob_full       = (rob_q == CW'(ROB_DEPTH));
    assign rob_empty      = (rob_q == '0);
    assign frontend_stall = stall_q;
    assign free_now       = CW'(ROB_DEPTH) - rob_q;

    lane_grant #(
        .W  (DISPATCH_W),
        .CW (CW)
    ) u_lane_grant (
        .valid_i (instruction),
        .free_i  (free_now),
        .grant_o (lane_gnt)
    );

    // Nothing allocates while resetting, recovering, or when downstream is blocked.
    always_comb begin
        dispatch_grant = lane_gnt;
        if (reset || flushing || rs_full || busy) begin
            dispatch_grant = '0;
        end
    end

    // Recovery sequencing; a new redirect always restarts from FLUSH.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (overwrite_pc) begin
            state_d = FLUSH;
        end else begin
            case (state_q)
                RUN: ;
                FLUSH: begin
                    if (FLUSH_CYCLES == 1) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        state_d = REFILL;
                        cnt_d   = FCW'(FLUSH_CYCLES - 1);
                    end
                end
                REFILL: begin
                    if (cnt_q <= FCW'(1)) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - FCW'(1);
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Occupancy: allocate and retire both apply; a redirect discards everything.
    always_comb begin
        tot       = {1'b0, rob_q} + (CW+1)'(popcount(MAX_LANES'(dispatch_grant)));
        underflow = ((CW+1)'(retire_count) > tot);
        if (overwrite_pc || (state_q == FLUSH)) begin
            rob_d = '0;
        end else if (underflow) begin
            rob_d = '0;
        end else begin
            rob_d = CW'(tot - (CW+1)'(retire_count));
        end
    end

    // Stall fetch next cycle if any cause holds against the next-cycle state.
    always_comb begin
        free_next = CW'(ROB_DEPTH) - rob_d;
        stall_d   = reset | busy | overwrite_pc | (state_d != RUN) | rs_full
                  | ({1'b0, free_next} < (CW+1)'(DISPATCH_W))
                  | ((instruction == '0) && (state_d == RUN));
    end

    // State registers; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
            rob_q   <= '0;
            stall_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rob_q   <= rob_d;
            stall_q <= stall_d;
        end
    end

    // Commit must never retire more entries than exist.
    a_no_underflow : assert property (@(posedge clk) disable iff (reset)
        !(underflow && !overwrite_pc && (state_q != FLUSH)));

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cyc_q, full_cyc_q, flush_cnt_q;

    assign stall_cycles = stall_cyc_q;
    assign full_cycles  = full_cyc_q;
    assign flush_count  = flush_cnt_q;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cyc_q <= '0;
            full_cyc_q  <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_q && (stall_cyc_q != '1)) stall_cyc_q <= stall_cyc_q + 32'd1;
            if (rob_full && (full_cyc_q != '1)) full_cyc_q <= full_cyc_q + 32'd1;
            if (overwrite_pc && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit against a cycle-level behavioural model.
module tb_hazard_unit;

    localparam int DEPTH = 32;
    localparam int DW    = 2;
    localparam int RTW   = 2;
    localparam int FC    = 2;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int RW    = $clog2(RTW + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          busy = 1'b0;
    logic          overwrite_pc = 1'b0;
    logic [DW-1:0] instruction = '0;
    logic [RW-1:0] retire_count = '0;
    logic          rs_full = 1'b0;
    logic [DW-1:0] dispatch_grant;
    logic [CW-1:0] rob_count;
    logic          rob_full, rob_empty, frontend_stall, flushing;
`ifdef HAZARD_PERF_EN
    logic [31:0]   stall_cycles, full_cycles, flush_count;
`endif

    always #5 clk = ~clk;

    hazard_unit #(
        .ROB_DEPTH    (DEPTH),
        .DISPATCH_W   (DW),
        .RETIRE_W     (RTW),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .busy           (busy),
        .overwrite_pc   (overwrite_pc),
        .instruction    (instruction),
        .retire_count   (retire_count),
        .rs_full        (rs_full),
        .dispatch_grant (dispatch_grant),
        .rob_count      (rob_count),
        .rob_full       (rob_full),
        .rob_empty      (rob_empty),
        .frontend_stall (frontend_stall),
        .flushing       (flushing)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cycles   (stall_cycles),
        .full_cycles    (full_cycles),
        .flush_count    (flush_count)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Model state: occupancy, remaining recovery cycles, registered stall.
    int m_occ   = 0;
    int m_rem   = 0;
    bit m_stall = 1'b1;
    int m_sc    = 0;
    int m_fc    = 0;
    int m_fl    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, check outputs, advance the model.
    task automatic step(input bit rst, input bit bsy, input bit ovw, input bit rsf,
                        input int nins, input int ret);
        int g, free, occ_n, rem_n;
        bit stall_n;
        logic [DW-1:0] ins, gexp;
        @(negedge clk);
        ins  = DW'((1 << nins) - 1);
        free = DEPTH - m_occ;
        if (rst || (m_rem > 0) || rsf || bsy) g = 0;
        else g = (nins < free) ? nins : free;
        if (ret > RTW) ret = RTW;
        if (ret > m_occ + g) ret = m_occ + g;
        reset        = rst;
        busy         = bsy;
        overwrite_pc = ovw;
        rs_full      = rsf;
        instruction  = ins;
        retire_count = RW'(ret);
        #1;
        gexp = DW'((1 << g) - 1);
        chk("grant",     32'(dispatch_grant), 32'(gexp));
        chk("rob_count", 32'(rob_count),      32'(m_occ));
        chk("rob_full",  32'(rob_full),       32'(m_occ == DEPTH));
        chk("rob_empty", 32'(rob_empty),      32'(m_occ == 0));
        chk("stall",     32'(frontend_stall), 32'(m_stall));
        chk("flushing",  32'(flushing),       32'(m_rem > 0));
`ifdef HAZARD_PERF_EN
        chk("stall_cycles", stall_cycles, 32'(m_sc));
        chk("full_cycles",  full_cycles,  32'(m_fc));
        chk("flush_count",  flush_count,  32'(m_fl));
`endif
        if (rst) begin
            m_occ = 0; m_rem = 0; m_stall = 1'b1;
            m_sc = 0; m_fc = 0; m_fl = 0;
        end else begin
            m_sc += int'(m_stall);
            m_fc += int'(m_occ == DEPTH);
            m_fl += int'(ovw);
            occ_n   = ovw ? 0 : m_occ + g - ret;
            rem_n   = ovw ? FC : ((m_rem > 0) ? m_rem - 1 : 0);
            stall_n = bsy || ovw || (rem_n > 0) || rsf || ((DEPTH - occ_n) < DW)
                   || ((nins == 0) && (rem_n == 0));
            m_occ = occ_n; m_rem = rem_n; m_stall = stall_n;
        end
    endtask

    initial begin
        // Reset for three cycles, then dispatch pairs until the ROB fills.
        repeat (3) step(1, 0, 0, 0, 2, 0);
        step(0, 0, 0, 0, 2, 0);
        chk("tp_first_grant", 32'(dispatch_grant), 32'h3);
        repeat (15) step(0, 0, 0, 0, 2, 0);
        step(0, 0, 0, 0, 2, 1);
        chk("tp_full", 32'(rob_full), 32'h1);
        chk("tp_full_grant", 32'(dispatch_grant), 32'h0);
        step(0, 0, 0, 0, 2, 0);
        chk("tp_one_slot_grant", 32'(dispatch_grant), 32'h1);
        // Drain to 10, then allocate and retire two each in the same cycle.
        repeat (11) step(0, 0, 0, 0, 0, 2);
        step(0, 0, 0, 0, 2, 2);
        chk("tp_rob10", 32'(rob_count), 32'd10);
        repeat (5) step(0, 0, 0, 0, 2, 0);
        // Redirect at 20 entries, then a second redirect during REFILL.
        step(0, 0, 1, 0, 0, 0);
        chk("tp_rob20", 32'(rob_count), 32'd20);
        step(0, 0, 0, 0, 2, 0);
        chk("tp_flush_rob", 32'(rob_count), 32'd0);
        step(0, 0, 1, 0, 2, 0);
        step(0, 0, 0, 0, 2, 0);
        step(0, 0, 0, 0, 2, 0);
        step(0, 0, 0, 0, 2, 0);
        chk("tp_back_to_run", 32'(flushing), 32'h0);
        // Reset in the middle of recovery.
        step(0, 0, 1, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("tp_reset_mid_flush", 32'(flushing), 32'h0);

        // Randomized traffic, alternating fill-biased and drain-biased phases.
        for (int i = 0; i < 3000; i++) begin
            int ret;
            if (((i / 300) % 2) == 1) ret = int'($urandom_range(0, RTW));
            else ret = (($urandom % 4) == 0) ? 1 : 0;
            step(($urandom % 150) == 0, ($urandom % 10) == 0, ($urandom % 40) == 0,
                 ($urandom % 10) == 0, int'($urandom_range(0, DW)), ret);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
